// File: rtl/cbpa.sv
// Registered carry-bypass (carry-skip) adder with a ripple-carry cross-check flag.
// Carries ripple inside fixed-size blocks and jump a whole block when every bit in it propagates.
module cbpa #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             of
);

    localparam int NBLK = WIDTH / BLOCK;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_ci;
    logic [WIDTH-1:0] w_s;
    logic [NBLK-1:0]  w_blkP;
    logic [NBLK:0]    w_blkC;
    logic             w_rippleCout;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_of;

    assign w_p = a ^ b;
    assign w_g = a & b;
    assign w_s = w_p ^ w_ci;

    // Each block ripples from its own carry-in; the skip mux picks the block carry-in when the block fully propagates.
    always_comb begin
        logic v_carry;
        w_ci      = '0;
        w_blkP    = '0;
        w_blkC    = '0;
        w_blkC[0] = Cin;
        for (int k = 0; k < NBLK; k++) begin
            w_blkP[k] = &w_p[k*BLOCK +: BLOCK];
            v_carry   = w_blkC[k];
            for (int j = 0; j < BLOCK; j++) begin
                w_ci[k*BLOCK + j] = v_carry;
                v_carry = w_g[k*BLOCK + j] | (w_p[k*BLOCK + j] & v_carry);
            end
            w_blkC[k+1] = w_blkP[k] ? w_blkC[k] : v_carry;
        end
    end

    // Independent full-width ripple, only used to cross-check the bypass carry.
    always_comb begin
        logic v_rc;
        v_rc = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            v_rc = w_g[i] | (w_p[i] & v_rc);
        end
        w_rippleCout = v_rc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_of   <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_blkC[NBLK];
            r_of   <= w_blkC[NBLK] ^ w_rippleCout;
        end
    end

    assign sum  = r_sum;
    assign Cout = r_cout;
    assign of   = r_of;

endmodule

// File: tb/tb_cbpa.sv
// Directed and random checks for the registered carry-bypass adder cbpa.
module tb_cbpa;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        Cin;
    logic [31:0] sum;
    logic        Cout;
    logic        of;

    int errors;
    int checks;

    cbpa #(.WIDTH(32), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .Cin (Cin),
        .sum (sum),
        .Cout(Cout),
        .of  (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        a   = 32'hDEADBEEF;
        b   = 32'h12345678;
        Cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sum !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_sum got=%h want=%h", sum, 32'h0);
        end
        checks++;
        if (Cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cout got=%b want=0", Cout);
        end
        checks++;
        if (of !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_of got=%b want=0", of);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va  [7] = '{32'h7FFFFFFF, 32'h8FFFFFFF, 32'h000007AA, 32'h000000AF,
                                 32'hFFFFFFFF, 32'h00000123, 32'hFFFFF999};
        logic [31:0] vb  [7] = '{32'h7FFFFFFF, 32'h8FFFFFFF, 32'hFFFFFFFF, 32'h000000AF,
                                 32'hFFFFFFFF, 32'hFFFFF123, 32'h00000111};
        logic        vc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] es  [7] = '{32'hFFFFFFFE, 32'h1FFFFFFE, 32'h000007A9, 32'h0000015F,
                                 32'hFFFFFFFE, 32'hFFFFF246, 32'hFFFFFAAA};
        logic        ec  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            a   = va[i];
            b   = vb[i];
            Cin = vc[i];
            @(posedge clk);
            #1;
            checks++;
            if ({Cout, sum, of} !== {ec[i], es[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL directed_%0d got cout=%b sum=%h of=%b want cout=%b sum=%h of=0",
                         i, Cout, sum, of, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_skip_boundary();
        a   = 32'h0;
        b   = 32'hFFFFFFFF;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum, of} !== {1'b0, 32'hFFFFFFFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL skip_cin0 got cout=%b sum=%h of=%b want cout=0 sum=ffffffff of=0",
                     Cout, sum, of);
        end
        Cin = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum, of} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL skip_cin1 got cout=%b sum=%h of=%b want cout=1 sum=00000000 of=0",
                     Cout, sum, of);
        end
        // Alternating-nibble all-propagate pattern with carry in.
        a   = 32'hA5A5A5A5;
        b   = 32'h5A5A5A5A;
        Cin = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum, of} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL skip_alt got cout=%b sum=%h of=%b want cout=1 sum=00000000 of=0",
                     Cout, sum, of);
        end
    endtask

    task automatic test_back_to_back();
        a   = 32'h00000001;
        b   = 32'h00000002;
        Cin = 1'b0;
        @(posedge clk);
        #1;
        a   = 32'h0000000F;
        b   = 32'h00000001;
        Cin = 1'b0;
        checks++;
        if ({Cout, sum} !== {1'b0, 32'h00000003}) begin
            errors++;
            $display("[TB] FAIL b2b_first got cout=%b sum=%h want cout=0 sum=00000003", Cout, sum);
        end
        #3;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        checks++;
        if ({Cout, sum} !== {1'b0, 32'h00000003}) begin
            errors++;
            $display("[TB] FAIL midcycle_hold got cout=%b sum=%h want cout=0 sum=00000003", Cout, sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum} !== {1'b1, 32'hFFFFFFFE}) begin
            errors++;
            $display("[TB] FAIL b2b_second got cout=%b sum=%h want cout=1 sum=fffffffe", Cout, sum);
        end
    endtask

    task automatic test_reset_mid_stream();
        a   = 32'h12345678;
        b   = 32'h11111111;
        Cin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum, of} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrst_clear got cout=%b sum=%h of=%b want all zero", Cout, sum, of);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, sum} !== {1'b0, 32'h2345678A}) begin
            errors++;
            $display("[TB] FAIL midrst_resume got cout=%b sum=%h want cout=0 sum=2345678a", Cout, sum);
        end
    endtask

    task automatic test_random();
        logic [32:0] expected;
        for (int i = 0; i < 300; i++) begin
            a   = $urandom;
            b   = (i % 5 == 0) ? ~a : $urandom;
            Cin = 1'($urandom_range(0, 1));
            expected = {1'b0, a} + {1'b0, b} + {32'b0, Cin};
            @(posedge clk);
            #1;
            checks++;
            if ({Cout, sum, of} !== {expected, 1'b0}) begin
                errors++;
                $display("[TB] FAIL random_%0d got cout=%b sum=%h of=%b want cout=%b sum=%h of=0",
                         i, Cout, sum, of, expected[32], expected[31:0]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        Cin    = 1'b0;
        test_reset();
        test_directed();
        test_skip_boundary();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
